// File: rtl/adrv9001_enable_sequencer.sv
// TDD enable scheduler for the four ADRV9001 channel-enable pins: a frame counter
// drives per-channel on/off windows with RX/TX pair exclusivity and frame-aligned start/stop.

module adrv9001_window #(
  parameter int CNT_W = 24
) (
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] on,
  input  logic [CNT_W-1:0] off,
  output logic             active
);
  // on > off is a window that wraps through the frame boundary
  always_comb begin
    if (on < off)      active = (count >= on) && (count < off);
    else if (on > off) active = (count >= on) || (count < off);
    else               active = 1'b0;
  end
endmodule

module adrv9001_enable_sequencer #(
  parameter int CNT_W = 24,
  parameter int FRM_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [FRM_W-1:0] frame_limit,
  input  logic [CNT_W-1:0] rx1_on,
  input  logic [CNT_W-1:0] rx1_off,
  input  logic [CNT_W-1:0] rx2_on,
  input  logic [CNT_W-1:0] rx2_off,
  input  logic [CNT_W-1:0] tx1_on,
  input  logic [CNT_W-1:0] tx1_off,
  input  logic [CNT_W-1:0] tx2_on,
  input  logic [CNT_W-1:0] tx2_off,
  input  logic             conflict_clr,
  output logic             rx1_en,
  output logic             rx2_en,
  output logic             tx1_en,
  output logic             tx2_en,
  output logic             busy,
  output logic             frame_done,
  output logic [FRM_W-1:0] frame_num,
  output logic             conflict
);
  localparam int NUM_CH = 4;  // lane order: rx1, rx2, tx1, tx2

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]                    state;
  logic                          last;
  logic [CNT_W-1:0]              count, len_q;
  logic [FRM_W-1:0]              limit_q, num_inc;
  logic [NUM_CH-1:0][CNT_W-1:0]  on_in, off_in, on_q, off_q;
  logic [NUM_CH-1:0]             act, en_d, en_q;
  logic                          running, frm_end, ovl1, ovl2, limit_hit, exit_now;

  assign on_in  = {tx2_on,  tx1_on,  rx2_on,  rx1_on};
  assign off_in = {tx2_off, tx1_off, rx2_off, rx1_off};

  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
      adrv9001_window #(.CNT_W(CNT_W)) u_win (
        .count  (count),
        .on     (on_q[ch]),
        .off    (off_q[ch]),
        .active (act[ch])
      );
    end
  endgenerate

  // last marks the frame_done cycle after the final frame; outputs hold there, then drop
  assign running   = (state != S_IDLE) && !last;
  assign frm_end   = running && (count == len_q);
  assign ovl1      = act[0] & act[2];
  assign ovl2      = act[1] & act[3];
  assign en_d      = {act[3] & ~ovl2, act[2] & ~ovl1, act[1] & ~ovl2, act[0] & ~ovl1};
  assign num_inc   = (&frame_num) ? frame_num : frame_num + FRM_W'(1);
  assign limit_hit = (limit_q != '0) && (num_inc == limit_q);
  assign exit_now  = limit_hit || !enable || (state == S_STOP);

  assign busy = (state != S_IDLE);
  assign {tx2_en, tx1_en, rx2_en, rx1_en} = en_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      last       <= 1'b0;
      count      <= '0;
      len_q      <= '0;
      limit_q    <= '0;
      on_q       <= '0;
      off_q      <= '0;
      en_q       <= '0;
      frame_done <= 1'b0;
      frame_num  <= '0;
      conflict   <= 1'b0;
    end else begin
      frame_done <= frm_end;
      conflict   <= (conflict & ~conflict_clr) | (running & (ovl1 | ovl2));
      if (state == S_IDLE) begin
        en_q  <= '0;
        count <= '0;
        last  <= 1'b0;
        if (enable) begin
          state     <= S_RUN;
          frame_num <= '0;
          len_q     <= frame_len;
          limit_q   <= frame_limit;
          on_q      <= on_in;
          off_q     <= off_in;
        end
      end else if (last) begin
        state <= S_IDLE;
        last  <= 1'b0;
        en_q  <= '0;
        count <= '0;
      end else begin
        en_q <= en_d;
        if (frm_end) begin
          // shadows reload only here so config edits land on frame boundaries
          count     <= '0;
          frame_num <= num_inc;
          len_q     <= frame_len;
          limit_q   <= frame_limit;
          on_q      <= on_in;
          off_q     <= off_in;
          last      <= exit_now;
        end else begin
          count <= count + CNT_W'(1);
          state <= enable ? S_RUN : S_STOP;
        end
      end
    end
  end
endmodule

// File: tb/tb_adrv9001_enable_sequencer.sv
// Directed and randomized checks of the enable sequencer against a per-cycle
// model derived from frame arithmetic (count = cycle mod period).

module tb_adrv9001_enable_sequencer;
  logic        clk = 1'b0, rstn = 1'b0, enable = 1'b0, conflict_clr = 1'b0;
  logic [23:0] frame_len = '0;
  logic [15:0] frame_limit = '0;
  logic [23:0] rx1_on = '0, rx1_off = '0, rx2_on = '0, rx2_off = '0;
  logic [23:0] tx1_on = '0, tx1_off = '0, tx2_on = '0, tx2_off = '0;
  logic        rx1_en, rx2_en, tx1_en, tx2_en, busy, frame_done, conflict;
  logic [15:0] frame_num;

  int    total = 0, bad = 0, tcur = 0;
  string cur = "reset";
  int    m_L = 0, m_chg_t = 0, m_chg_val = 0;
  int    m_on[4], m_off[4];

  adrv9001_enable_sequencer dut (
    .clk(clk), .rstn(rstn), .enable(enable), .frame_len(frame_len), .frame_limit(frame_limit),
    .rx1_on(rx1_on), .rx1_off(rx1_off), .rx2_on(rx2_on), .rx2_off(rx2_off),
    .tx1_on(tx1_on), .tx1_off(tx1_off), .tx2_on(tx2_on), .tx2_off(tx2_off),
    .conflict_clr(conflict_clr), .rx1_en(rx1_en), .rx2_en(rx2_en), .tx1_en(tx1_en),
    .tx2_en(tx2_en), .busy(busy), .frame_done(frame_done), .frame_num(frame_num),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s t=%0d got=%0b want=%0b", cur, tag, tcur, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s t=%0d got=%0d want=%0d", cur, tag, tcur, obs, exp);
    end
  endtask

  function automatic logic win(input int c, input int on, input int off);
    if (on < off) return (c >= on) && (c < off);
    if (on > off) return (c >= on) || (c < off);
    return 1'b0;
  endfunction

  // raw window activity while the count of run cycle s (s = 1 is count 0) is presented
  function automatic logic [3:0] act_at(input int s);
    int c, f, on1;
    logic [3:0] a;
    c   = (s - 1) % (m_L + 1);
    f   = (s - 1) / (m_L + 1);
    on1 = (m_chg_t > 0 && f >= 1 && f * (m_L + 1) >= m_chg_t) ? m_chg_val : m_on[1];
    a[0] = win(c, m_on[0], m_off[0]);
    a[1] = win(c, on1,     m_off[1]);
    a[2] = win(c, m_on[2], m_off[2]);
    a[3] = win(c, m_on[3], m_off[3]);
    return a;
  endfunction

  function automatic logic [3:0] excl(input logic [3:0] a);
    logic [3:0] e;
    e = a;
    if (a[0] && a[2]) begin e[0] = 1'b0; e[2] = 1'b0; end
    if (a[1] && a[3]) begin e[1] = 1'b0; e[3] = 1'b0; end
    return e;
  endfunction

  function automatic logic [3:0][7:0] w4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic set_win(input logic [3:0][7:0] on, input logic [3:0][7:0] off);
    rx1_on = 24'(on[0]); rx2_on = 24'(on[1]); tx1_on = 24'(on[2]); tx2_on = 24'(on[3]);
    rx1_off = 24'(off[0]); rx2_off = 24'(off[1]); tx1_off = 24'(off[2]); tx2_off = 24'(off[3]);
    for (int i = 0; i < 4; i++) begin
      m_on[i]  = int'(on[i]);
      m_off[i] = int'(off[i]);
    end
  endtask

  // One run from IDLE to IDLE. Limit mode when lim != 0, otherwise enable drops
  // at drop_t (optionally re-raised at rise_t and dropped again at drop2_t).
  task automatic run(input string name, input int L, input int lim,
                     input logic [3:0][7:0] on, input logic [3:0][7:0] off,
                     input int drop_t, input int rise_t, input int drop2_t,
                     input int clr_t, input int chg_t, input int chg_val);
    int N, T, fin, fn;
    logic exp_conf;
    logic [3:0] a, e;
    cur = name; m_L = L; m_chg_t = chg_t; m_chg_val = chg_val;
    set_win(on, off);
    conflict_clr = 1'b1;
    @(negedge clk);
    conflict_clr = 1'b0;
    frame_len = 24'(L); frame_limit = 16'(lim); enable = 1'b1; tcur = 0;
    chk("busy_idle", busy, 1'b0);
    chk("conflict_idle", conflict, 1'b0);
    if (lim != 0) N = lim;
    else begin
      fin = (rise_t > 0) ? drop2_t : drop_t;
      N = (fin - 1) / (L + 1) + 1;
    end
    T = N * (L + 1) + 1;
    exp_conf = 1'b0;
    for (int t = 1; t <= T + 3; t++) begin
      @(negedge clk);
      tcur = t;
      e = (t >= 2 && t <= T) ? excl(act_at(t - 1)) : 4'b0;
      fn = (t - 1) / (L + 1);
      if (fn > N) fn = N;
      chk("rx1_en", rx1_en, e[0]);
      chk("rx2_en", rx2_en, e[1]);
      chk("tx1_en", tx1_en, e[2]);
      chk("tx2_en", tx2_en, e[3]);
      chk("busy", busy, t <= T);
      chk("frame_done", frame_done, t >= 2 && t <= T && ((t - 1) % (L + 1) == 0));
      chkn("frame_num", int'(frame_num), fn);
      chk("conflict", conflict, exp_conf);
      a = (t <= N * (L + 1)) ? act_at(t) : 4'b0;
      exp_conf = (exp_conf & !(t == clr_t)) | (a[0] & a[2]) | (a[1] & a[3]);
      if (lim != 0) enable = (t < T);
      else enable = !(t >= drop_t && (rise_t == 0 || t < rise_t || t >= drop2_t));
      conflict_clr = (t == clr_t);
      if (chg_t > 0 && t == chg_t) rx2_on = 24'(chg_val);
    end
    enable = 1'b0;
    conflict_clr = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    logic [3:0][7:0] ron, roff;
    int L, N;

    repeat (2) @(negedge clk);
    chk("rx1_en", rx1_en, 1'b0);
    chk("tx2_en", tx2_en, 1'b0);
    chk("busy", busy, 1'b0);
    chk("frame_done", frame_done, 1'b0);
    chkn("frame_num", int'(frame_num), 0);
    chk("conflict", conflict, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    run("basic",    9, 2, w4(2, 0, 0, 0), w4(5, 0, 0, 0), 0, 0, 0, 0, 0, 0);
    run("wrapped",  7, 2, w4(0, 0, 0, 6), w4(0, 0, 0, 2), 0, 0, 0, 0, 0, 0);
    run("conflict", 9, 1, w4(1, 0, 4, 0), w4(6, 0, 8, 0), 0, 0, 0, 13, 0, 0);
    run("clr_race", 9, 1, w4(1, 0, 4, 0), w4(6, 0, 8, 0), 0, 0, 0, 6, 0, 0);
    run("graceful", 4, 0, w4(1, 0, 0, 3), w4(3, 0, 0, 0), 24, 0, 0, 0, 0, 0);
    run("reraise",  4, 0, w4(0, 2, 1, 0), w4(2, 4, 4, 0), 7, 9, 13, 0, 0, 0);
    run("cfg_edge", 9, 2, w4(0, 2, 0, 0), w4(0, 6, 0, 0), 0, 0, 0, 0, 3, 4);
    run("len0",     0, 3, w4(0, 0, 0, 1), w4(1, 1, 0, 0), 0, 0, 0, 0, 0, 0);
    run("off_past", 5, 1, w4(2, 0, 0, 0), w4(9, 0, 0, 0), 0, 0, 0, 0, 0, 0);

    // asynchronous reset mid-frame (frame 1, count 4) with tx1_en high
    cur = "async_rst"; m_L = 9; m_chg_t = 0;
    set_win(w4(0, 1, 2, 3), w4(0, 6, 8, 5));
    conflict_clr = 1'b1;
    @(negedge clk);
    conflict_clr = 1'b0;
    frame_len = 24'd9; frame_limit = 16'd0; enable = 1'b1;
    repeat (15) @(negedge clk);
    tcur = 15;
    e = excl(act_at(14));
    chk("tx1_pre", tx1_en, e[2]);
    chk("tx1_pre_high", tx1_en, 1'b1);
    chkn("frame_num_pre", int'(frame_num), 1);
    chk("conflict_pre", conflict, 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk("tx1_rst", tx1_en, 1'b0);
    chk("rx2_rst", rx2_en, 1'b0);
    chk("busy_rst", busy, 1'b0);
    chk("frame_done_rst", frame_done, 1'b0);
    chkn("frame_num_rst", int'(frame_num), 0);
    chk("conflict_rst", conflict, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run("restart", 9, 1, w4(0, 1, 2, 3), w4(0, 6, 8, 5), 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 12; k++) begin
      L = $urandom_range(0, 12);
      N = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        ron[i]  = 8'($urandom_range(0, L));
        roff[i] = 8'($urandom_range(0, L + 2));
      end
      if ($urandom_range(0, 1) == 1)
        run("rand_lim", L, N, ron, roff, 0, 0, 0, $urandom_range(1, N * (L + 1) + 3), 0, 0);
      else
        run("rand_drop", L, 0, ron, roff, (N - 1) * (L + 1) + 1 + $urandom_range(0, L), 0, 0,
            $urandom_range(1, N * (L + 1) + 3), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
